// File: rtl/ecc_pkg.sv
// -----------------------------------------------------------------------------
// ecc_pkg
// Shared constants and types for the GF(2^163) point-arithmetic datapath
// (adder, multiplier, divider).
//
// Contents:
//   M       field degree (163)
//   F_POLY  full reduction polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1
//   F_LOW   f(x) with the leading term dropped (bits 7,6,3,0)
//   div_state_t  divider FSM states
// -----------------------------------------------------------------------------
package ecc_pkg;

  localparam int M = 163;

  localparam logic [M:0]   F_POLY = (164'd1 << M) | 164'hC9;
  localparam logic [M-1:0] F_LOW  = 163'hC9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/ff_div_x.sv
// -----------------------------------------------------------------------------
// ff_div_x
// Purely combinational division by x in GF(2^163): h = g * x^-1 mod f(x).
// Used by the divider for both accumulators and reusable by point halving.
//
// Ports:
//   g  in  [M-1:0]  field element
//   h  out [M-1:0]  g / x mod f
// -----------------------------------------------------------------------------
module ff_div_x
  import ecc_pkg::*;
(
  input  logic [M-1:0] g,
  output logic [M-1:0] h
);

  logic [M-1:0] g_plus_f;

  // Adding f clears bit 0 of an odd g; the x^163 term of f lands in bit 162
  // after the shift, which is why the top bit is forced to 1.
  assign g_plus_f = g ^ F_LOW;

  always_comb begin
    h = {1'b0, g[M-1:1]};
    if (g[0]) begin
      h = {1'b1, g_plus_f[M-1:1]};
    end
  end

endmodule

// File: rtl/ff_divider.sv
// -----------------------------------------------------------------------------
// ff_divider
// Sequential GF(2^163) divider: c = a * b^-1 mod f(x), using the binary
// extended Euclidean algorithm with one elementary step per clock.
//
// Invariants held while running: g1 * b == a * u and g2 * b == a * v (mod f).
// When u or v reaches 1, the matching accumulator is the quotient.
//
// Handshake: start is a single-cycle request sampled together with a and b;
// it is accepted only while the FSM is IDLE (busy low) and ignored otherwise.
// busy is high from the cycle after an accepted start up to, but not
// including, the done cycle. done is a one-cycle pulse; c and err are valid
// with done and held until overwritten by the next completed operation.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request pulse
//   a      in   [M-1:0] dividend
//   b      in   [M-1:0] divisor
//   busy   out  operation in flight
//   done   out  result pulse
//   c      out  [M-1:0] quotient
//   err    out  divide-by-zero (b == 0)
//
// The FSM state register state_q is the observation point for checkers.
// -----------------------------------------------------------------------------
module ff_divider
  import ecc_pkg::*;
#(
  parameter int M = ecc_pkg::M  // fixed at 163; other values unsupported
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c,
  output logic         err
);

  div_state_t   state_q, state_d;
  logic [M:0]   u_q, u_d;
  logic [M:0]   v_q, v_d;
  logic [M-1:0] g1_q, g1_d;
  logic [M-1:0] g2_q, g2_d;
  logic [M-1:0] c_q, c_d;
  logic         err_q, err_d;
  logic         done_q, done_d;

  logic [M-1:0] g1_half, g2_half;
  logic         u_is_one, v_is_one;
  logic         u_gt_v;

  ff_div_x u_div_x_g1 (
    .g (g1_q),
    .h (g1_half)
  );

  ff_div_x u_div_x_g2 (
    .g (g2_q),
    .h (g2_half)
  );

  localparam logic [M:0] ONE = {{M{1'b0}}, 1'b1};

  assign u_is_one = (u_q == ONE);
  assign v_is_one = (v_q == ONE);
  // Plain integer compare stands in for a degree compare: a larger value
  // never has a smaller degree, and for equal degrees either branch works.
  assign u_gt_v   = (u_q > v_q);

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    c_d     = c_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            // No inverse exists; report immediately without entering RUN.
            c_d    = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            u_d     = {1'b0, b};
            v_d     = F_POLY;
            g1_d    = a;
            g2_d    = '0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (u_is_one) begin
          c_d     = g1_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (v_is_one) begin
          c_d     = g2_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          g1_d = g1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          g2_d = g2_half;
        end else if (u_gt_v) begin
          u_d  = u_q ^ v_q;
          g1_d = g1_q ^ g2_q;
        end else begin
          v_d  = v_q ^ u_q;
          g2_d = g2_q ^ g1_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      c_q     <= c_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // busy is exactly "in RUN": it drops on the same edge that raises done.
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign c    = c_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ff_divider.sv
// -----------------------------------------------------------------------------
// tb_ff_divider
// Self-checking bench for ff_divider. Quotients are checked through field
// multiplication: c * b mod f must reproduce a.
// -----------------------------------------------------------------------------
module tb_ff_divider;

  localparam int           W        = 163;
  localparam logic [W-1:0] TB_F_LOW = 163'hC9;
  localparam int           MAX_LAT  = 652;
  localparam int           TIMEOUT  = 660;
  localparam int           N_RAND   = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] c;
  logic         err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [W-1:0] exp_q[$];

  ff_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .err   (err)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ------------------------------------------------------------- helpers
  function automatic logic [W-1:0] rand_elem();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Schoolbook polynomial product, reduced one bit at a time (Horner on b).
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc;
    logic         top;
    acc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      top = acc[W-1];
      acc = acc << 1;
      if (top) acc = acc ^ TB_F_LOW;
      if (y[i]) acc = acc ^ x;
    end
    return acc;
  endfunction

  // ------------------------------------------------------------- driver
  // Issues one request and waits for done. lat counts cycles from the start
  // edge to the done cycle. shape_err counts protocol violations: busy low
  // before done, busy high with done, a done wider than one cycle, or c/err
  // changing in the cycle after done. With inject set, extra start pulses
  // carrying junk operands are thrown in while busy is high.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit inject,
                        output logic [W-1:0] co, output logic eo, output int lat,
                        output int shape_err, output bit tmo);
    shape_err = 0;
    tmo       = 1'b0;
    lat       = 0;
    co        = '0;
    eo        = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < TIMEOUT) begin
      if (!busy) shape_err++;
      if (inject && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        a     = rand_elem();
        b     = rand_elem();
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (!done) begin
      tmo = 1'b1;
    end else begin
      if (busy) shape_err++;
      co = c;
      eo = err;
      @(negedge clk);
      if (done) shape_err++;
      if (c !== co || err !== eo) shape_err++;
    end
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++;
    if (c !== '0) $display("FAIL reset_c: got %h want 0", c); else pass_cnt++;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_unit();
    logic [W-1:0] co;
    logic         eo;
    int           lat, se;
    bit           tmo;
    run_op(163'd1, 163'd1, 1'b0, co, eo, lat, se, tmo);
    chk_cnt++;
    if (tmo || lat != 2) $display("FAIL unit_latency: got %0d want 2 (timeout=%0b)", lat, tmo); else pass_cnt++;
    chk_cnt++;
    if (co !== 163'd1) $display("FAIL unit_c: got %h want 1", co); else pass_cnt++;
    chk_cnt++;
    if (eo !== 1'b0) $display("FAIL unit_err: got %b want 0", eo); else pass_cnt++;
    chk_cnt++;
    if (se != 0) $display("FAIL unit_shape: got %0d violations want 0", se); else pass_cnt++;
  endtask

  task automatic test_inv_x();
    logic [W-1:0] co, expv;
    logic         eo;
    int           lat, se;
    bit           tmo;
    expv      = '0;
    expv[162] = 1'b1;
    expv[6]   = 1'b1;
    expv[5]   = 1'b1;
    expv[2]   = 1'b1;
    run_op(163'd1, 163'd2, 1'b0, co, eo, lat, se, tmo);
    chk_cnt++;
    if (tmo || co !== expv) $display("FAIL inv_x_c: got %h want %h", co, expv); else pass_cnt++;
    chk_cnt++;
    if (eo !== 1'b0) $display("FAIL inv_x_err: got %b want 0", eo); else pass_cnt++;
    chk_cnt++;
    if (se != 0) $display("FAIL inv_x_shape: got %0d violations want 0", se); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    logic [W-1:0] co;
    logic         eo;
    int           lat, se;
    bit           tmo;
    run_op(163'h2A5, 163'd0, 1'b0, co, eo, lat, se, tmo);
    chk_cnt++;
    if (tmo || lat != 1) $display("FAIL div0_latency: got %0d want 1 (timeout=%0b)", lat, tmo); else pass_cnt++;
    chk_cnt++;
    if (eo !== 1'b1) $display("FAIL div0_err: got %b want 1", eo); else pass_cnt++;
    chk_cnt++;
    if (co !== '0) $display("FAIL div0_c: got %h want 0", co); else pass_cnt++;
    chk_cnt++;
    if (se != 0) $display("FAIL div0_shape: got %0d violations want 0", se); else pass_cnt++;
  endtask

  task automatic test_zero_dividend();
    logic [W-1:0] co, bi;
    logic         eo;
    int           lat, se;
    bit           tmo;
    bi = rand_elem();
    if (bi == '0) bi = 163'd3;
    run_op(163'd0, bi, 1'b0, co, eo, lat, se, tmo);
    chk_cnt++;
    if (tmo || lat > MAX_LAT) $display("FAIL zero_a_latency: got %0d want <= %0d", lat, MAX_LAT); else pass_cnt++;
    chk_cnt++;
    if (co !== '0) $display("FAIL zero_a_c: got %h want 0", co); else pass_cnt++;
    chk_cnt++;
    if (eo !== 1'b0) $display("FAIL zero_a_err: got %b want 0", eo); else pass_cnt++;
    chk_cnt++;
    if (se != 0) $display("FAIL zero_a_shape: got %0d violations want 0", se); else pass_cnt++;
  endtask

  // Back-to-back random divisions with junk start pulses during busy.
  task automatic test_random();
    logic [W-1:0] co, ai, bi, ea;
    logic         eo;
    int           lat, se;
    bit           tmo;
    for (int n = 0; n < N_RAND; n++) begin
      ai = rand_elem();
      bi = rand_elem();
      if (bi == '0) bi = 163'd1;
      exp_q.push_back(ai);
      run_op(ai, bi, 1'b1, co, eo, lat, se, tmo);
      ea = exp_q.pop_front();
      chk_cnt++;
      if (tmo || gf_mul(co, bi) !== ea)
        $display("FAIL rand_product[%0d]: c*b=%h want a=%h (timeout=%0b)", n, gf_mul(co, bi), ea, tmo);
      else pass_cnt++;
      chk_cnt++;
      if (eo !== 1'b0) $display("FAIL rand_err[%0d]: got %b want 0", n, eo); else pass_cnt++;
      chk_cnt++;
      if (lat > MAX_LAT) $display("FAIL rand_latency[%0d]: got %0d want <= %0d", n, lat, MAX_LAT); else pass_cnt++;
      chk_cnt++;
      if (se != 0) $display("FAIL rand_shape[%0d]: got %0d violations want 0", n, se); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] co, ai, bi;
    logic         eo;
    int           lat, se, done_seen;
    bit           tmo;
    bit           was_busy;
    ai      = rand_elem();
    bi      = rand_elem();
    bi[162] = 1'b1;  // high degree guarantees well over 100 RUN cycles
    @(negedge clk);
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    was_busy = busy;
    chk_cnt++;
    if (was_busy !== 1'b1) $display("FAIL mid_busy_before_rst: got %b want 1", was_busy); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++;
    if (c !== '0) $display("FAIL mid_rst_c: got %h want 0", c); else pass_cnt++;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", err); else pass_cnt++;
    rst       = 1'b0;
    done_seen = 0;
    if (done) done_seen++;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk_cnt++;
    if (done_seen != 0) $display("FAIL mid_rst_no_done: got %0d done/busy cycles want 0", done_seen); else pass_cnt++;
    run_op(ai, bi, 1'b0, co, eo, lat, se, tmo);
    chk_cnt++;
    if (tmo || gf_mul(co, bi) !== ai)
      $display("FAIL mid_rst_rerun: c*b=%h want a=%h (timeout=%0b)", gf_mul(co, bi), ai, tmo);
    else pass_cnt++;
    chk_cnt++;
    if (se != 0) $display("FAIL mid_rst_rerun_shape: got %0d violations want 0", se); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_unit();
    test_inv_x();
    test_div_zero();
    test_zero_dividend();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
